// File: rtl/clockworks_gearbox.sv
// Clock gearbox: divides CLK by 2^SLOW into clk and conditions RESET into
// a stretched, clk-aligned resetn. CLOCKWORKS_FAST_SIM_EN caps the exponent at 4.
module clockworks_gearbox #(
  parameter int SLOW         = 0,
  parameter int RESET_CYCLES = 4
) (
  input  logic CLK,
  input  logic RESET,
  output logic clk,
  output logic resetn
);

`ifdef CLOCKWORKS_FAST_SIM_EN
  localparam int DIV = (SLOW > 4) ? 4 : SLOW;
`else
  localparam int DIV = SLOW;
`endif

  localparam int SW = $clog2(RESET_CYCLES + 1);
  localparam logic [SW-1:0] SMAX = SW'(RESET_CYCLES);

  logic rise_tick;
  logic fall_tick;

  generate
    if (DIV == 0) begin : g_nodiv
      assign clk       = CLK;
      assign rise_tick = 1'b1;
      assign fall_tick = 1'b1;
    end else begin : g_div
      localparam logic [DIV-1:0] HALF_M1 = DIV'((1 << (DIV - 1)) - 1);
      localparam logic [DIV-1:0] TOP     = {DIV{1'b1}};

      logic [DIV-1:0] cnt_q;
      logic [DIV-1:0] cnt_d;

      assign cnt_d = cnt_q + DIV'(1);

      // free-running divider, wraps naturally at 2^DIV
      always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) cnt_q <= '0;
        else        cnt_q <= cnt_d;
      end

      assign clk       = cnt_q[DIV-1];
      assign rise_tick = (cnt_q == HALF_M1);
      assign fall_tick = (cnt_q == TOP);
    end
  endgenerate

  logic [1:0]    sync_q;
  logic [SW-1:0] stretch_q;
  logic [SW-1:0] stretch_d;
  logic          resetn_q;
  logic          resetn_d;

  // two-flop synchronizer of the release of RESET
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) sync_q <= 2'b00;
    else        sync_q <= {sync_q[0], 1'b1};
  end

  // count clk rising edges seen with reset released, release on a falling edge
  always_comb begin
    stretch_d = stretch_q;
    if (rise_tick && sync_q[1] && (stretch_q != SMAX))
      stretch_d = stretch_q + SW'(1);
    resetn_d = resetn_q | (fall_tick & (stretch_d == SMAX));
  end

  // stretch counter and glitch-free resetn flop
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      stretch_q <= '0;
      resetn_q  <= 1'b0;
    end else begin
      stretch_q <= stretch_d;
      resetn_q  <= resetn_d;
    end
  end

  assign resetn = resetn_q;

endmodule

// File: tb/tb_clockworks_gearbox.sv
// Bench for clockworks_gearbox: four parameterisations on a shared CLK/RESET,
// compared per CLK edge against an edge-arithmetic reference model.
module tb_clockworks_gearbox;

  logic       CLK = 1'b0;
  logic       RESET = 1'b0;
  logic [3:0] clk_w;
  logic [3:0] rstn_w;

  int checks = 0;
  int failures = 0;
  int k = 0;

  int sl[4] = '{2, 0, 3, 21};
  int rc[4] = '{4, 1, 4, 2};

  always #5 CLK = ~CLK;

  clockworks_gearbox #(.SLOW(2), .RESET_CYCLES(4)) u0 (
    .CLK(CLK), .RESET(RESET), .clk(clk_w[0]), .resetn(rstn_w[0]));
  clockworks_gearbox #(.SLOW(0), .RESET_CYCLES(1)) u1 (
    .CLK(CLK), .RESET(RESET), .clk(clk_w[1]), .resetn(rstn_w[1]));
  clockworks_gearbox #(.SLOW(3), .RESET_CYCLES(4)) u2 (
    .CLK(CLK), .RESET(RESET), .clk(clk_w[2]), .resetn(rstn_w[2]));
  clockworks_gearbox #(.SLOW(21), .RESET_CYCLES(2)) u3 (
    .CLK(CLK), .RESET(RESET), .clk(clk_w[3]), .resetn(rstn_w[3]));

  function automatic int eff(int s);
`ifdef CLOCKWORKS_FAST_SIM_EN
    return (s > 4) ? 4 : s;
`else
    return s;
`endif
  endfunction

  // edge (counted from release) at which resetn rises:
  // sync is high after edge 2, so rise ticks count from edge 3 on
  function automatic int rel_edge(int s, int n);
    int p;
    int cnt;
    bit rise;
    bit fall;
    p = 1 << s;
    cnt = 0;
    for (int e = 1; e <= 2000; e++) begin
      rise = (s == 0) || ((e % p) == p / 2);
      fall = (s == 0) || ((e % p) == 0);
      if (rise && e >= 3 && cnt < n) cnt++;
      if (fall && cnt >= n) return e;
    end
    return 1 << 30;
  endfunction

  task automatic chk(string tag, logic obs, logic exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s k=%0d obs=%b exp=%b", tag, k, obs, exp);
    end
  endtask

  task automatic check_all(bit in_rst);
    int s;
    int p;
    logic ec;
    logic er;
    for (int i = 0; i < 4; i++) begin
      s = eff(sl[i]);
      p = 1 << s;
      if (s == 0) ec = CLK;
      else if (in_rst) ec = 1'b0;
      else ec = ((k % p) >= p / 2);
      er = !in_rst && (k >= rel_edge(s, rc[i]));
      chk($sformatf("clk_u%0d", i), clk_w[i], ec);
      chk($sformatf("resetn_u%0d", i), rstn_w[i], er);
    end
  endtask

  task automatic run_edges(int n);
    for (int i = 0; i < n; i++) begin
      @(posedge CLK);
      k++;
      #2;
      check_all(1'b0);
    end
  endtask

  task automatic hold_reset(int n);
    for (int i = 0; i < n; i++) begin
      @(posedge CLK);
      #2;
      check_all(1'b1);
    end
  endtask

  task automatic release_reset();
    @(posedge CLK);
    #($urandom_range(3, 8));
    RESET = 1'b1;
    k = 0;
  endtask

  initial begin
    int m;
    // reset held low for 10 CLK periods
    hold_reset(10);

    // first release, long enough to cover every stretch and steady state
    release_reset();
    run_edges(70);

    // second release, reassert mid-stretch
    RESET = 1'b0;
    hold_reset($urandom_range(1, 5));
    release_reset();
    m = $urandom_range(10, 20);
    run_edges(m);
    #1;
    RESET = 1'b0;
    #1;
    check_all(1'b1);
    hold_reset($urandom_range(1, 5));
    release_reset();
    run_edges(70);

    // sub-period reset pulse
    @(posedge CLK);
    #2;
    RESET = 1'b0;
    #1;
    check_all(1'b1);
    #2;
    RESET = 1'b1;
    k = 0;
    run_edges(70);

    // random-length reassert after release
    #1;
    RESET = 1'b0;
    #1;
    check_all(1'b1);
    hold_reset($urandom_range(1, 3));
    release_reset();
    run_edges(50);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
